// File: rtl/rob_commit.sv
// Circular reorder buffer: allocates on dispatch, captures CDB results, retires in order one per cycle.
// Latency: CDB result for the head entry produces ROB_flag on the following clock edge (bypassed into commit).
// Backpressure: ROB_full drops dispatch; rdy=0 freezes all state; a registered roll flushes the buffer.
module rob_commit #(
    parameter int ROB_SIZE  = 16,
    parameter int ROB_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 Dis_flag,
    input  logic [1:0]           Dis_type,
    input  logic [4:0]           Dis_rd,
    input  logic [31:0]          Dis_pc,
    input  logic                 Dis_pred,
    output logic [ROB_IDX_W-1:0] ROB_free_idx,
    output logic                 ROB_full,
    input  logic [ROB_IDX_W-1:0] Q1_idx,
    output logic                 Q1_ready,
    output logic [31:0]          Q1_val,
    input  logic [ROB_IDX_W-1:0] Q2_idx,
    output logic                 Q2_ready,
    output logic [31:0]          Q2_val,
    input  logic                 CDB_flag,
    input  logic [ROB_IDX_W-1:0] CDB_idx,
    input  logic [31:0]          CDB_val,
    input  logic                 CDB_taken,
    input  logic [31:0]          CDB_target,
    output logic                 ROB_flag,
    output logic [ROB_IDX_W-1:0] ROB_new_idx,
    output logic [4:0]           ROB_rd,
    output logic [31:0]          ROB_val,
    output logic                 Store_commit,
    output logic                 roll,
    output logic [31:0]          roll_pc
);

    localparam logic [1:0]         TYPE_REG = 2'd0;
    localparam logic [1:0]         TYPE_BR  = 2'd1;
    localparam logic [1:0]         TYPE_ST  = 2'd2;
    localparam logic [ROB_IDX_W:0] FULL_CNT = (ROB_IDX_W+1)'(ROB_SIZE);

    logic [ROB_IDX_W-1:0] head, tail;
    logic [ROB_IDX_W:0]   count, count_nxt;
    logic [ROB_SIZE-1:0]  busy, ready;

    logic [1:0]  e_type   [ROB_SIZE];
    logic [4:0]  e_rd     [ROB_SIZE];
    logic [31:0] e_val    [ROB_SIZE];
    logic [31:0] e_pc     [ROB_SIZE];
    logic        e_pred   [ROB_SIZE];
    logic        e_taken  [ROB_SIZE];
    logic [31:0] e_target [ROB_SIZE];

    logic        dis_en, cdb_hit, cdb_head, commit_en, mispred;
    logic [31:0] h_val, h_target;
    logic        h_taken;

    assign ROB_full     = (count == FULL_CNT);
    assign ROB_free_idx = tail;

    // A CDB write aimed at the head entry is folded straight into this cycle's commit decision.
    assign dis_en    = Dis_flag && !ROB_full;
    assign cdb_hit   = CDB_flag && busy[CDB_idx];
    assign cdb_head  = cdb_hit && (CDB_idx == head);
    assign commit_en = (count != '0) && (ready[head] || cdb_head);
    assign h_val     = cdb_head ? CDB_val    : e_val[head];
    assign h_taken   = cdb_head ? CDB_taken  : e_taken[head];
    assign h_target  = cdb_head ? CDB_target : e_target[head];
    assign mispred   = (e_type[head] == TYPE_BR) && (h_taken != e_pred[head]);
    assign count_nxt = count + {{ROB_IDX_W{1'b0}}, dis_en} - {{ROB_IDX_W{1'b0}}, commit_en};

    // Operand forwarding: a same-cycle CDB broadcast beats the stored entry value.
    always_comb begin
        Q1_ready = 1'b0;
        Q1_val   = '0;
        Q2_ready = 1'b0;
        Q2_val   = '0;
        if (CDB_flag && CDB_idx == Q1_idx) begin
            Q1_ready = 1'b1;
            Q1_val   = CDB_val;
        end else if (busy[Q1_idx] && ready[Q1_idx]) begin
            Q1_ready = 1'b1;
            Q1_val   = e_val[Q1_idx];
        end
        if (CDB_flag && CDB_idx == Q2_idx) begin
            Q2_ready = 1'b1;
            Q2_val   = CDB_val;
        end else if (busy[Q2_idx] && ready[Q2_idx]) begin
            Q2_ready = 1'b1;
            Q2_val   = e_val[Q2_idx];
        end
    end

    // Pointers, entry status bits and the registered commit/roll outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            busy         <= '0;
            ready        <= '0;
            ROB_flag     <= 1'b0;
            ROB_new_idx  <= '0;
            ROB_rd       <= '0;
            ROB_val      <= '0;
            Store_commit <= 1'b0;
            roll         <= 1'b0;
            roll_pc      <= '0;
        end else if (roll) begin
            // Flush cycle: everything younger than the mispredicted branch is discarded.
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            busy         <= '0;
            ready        <= '0;
            ROB_flag     <= 1'b0;
            Store_commit <= 1'b0;
            roll         <= 1'b0;
        end else if (rdy) begin
            if (cdb_hit) begin
                ready[CDB_idx] <= 1'b1;
            end
            if (commit_en) begin
                busy[head]   <= 1'b0;
                ready[head]  <= 1'b0;
                head         <= head + ROB_IDX_W'(1);
                ROB_flag     <= 1'b1;
                ROB_new_idx  <= head;
                ROB_val      <= h_val;
                ROB_rd       <= (e_type[head] == TYPE_REG) ? e_rd[head] : 5'd0;
                Store_commit <= (e_type[head] == TYPE_ST);
                roll         <= mispred;
                if (mispred) begin
                    roll_pc <= h_taken ? h_target : e_pc[head] + 32'd4;
                end
            end else begin
                ROB_flag     <= 1'b0;
                Store_commit <= 1'b0;
            end
            // Tail never equals a committing head here: dispatch is dropped when full.
            if (dis_en) begin
                busy[tail]  <= 1'b1;
                ready[tail] <= 1'b0;
                tail        <= tail + ROB_IDX_W'(1);
            end
            count <= count_nxt;
        end
    end

    // Entry payload: dispatch fields and CDB results; validity lives in busy/ready.
    always_ff @(posedge clk) begin
        if (!rst && !roll && rdy) begin
            if (cdb_hit) begin
                e_val[CDB_idx]    <= CDB_val;
                e_taken[CDB_idx]  <= CDB_taken;
                e_target[CDB_idx] <= CDB_target;
            end
            if (dis_en) begin
                e_type[tail] <= Dis_type;
                e_rd[tail]   <= Dis_rd;
                e_pc[tail]   <= Dis_pc;
                e_pred[tail] <= Dis_pred;
            end
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed vector table, corner-case sequences and random traffic vs a queue model.
// Latency: inputs driven 1 time unit after posedge, outputs sampled before/after the following posedge.
// Backpressure: exercises full-drop, rdy hold and roll flush.
module tb_rob_commit;

    logic        clk, rst, rdy;
    logic        Dis_flag;
    logic [1:0]  Dis_type;
    logic [4:0]  Dis_rd;
    logic [31:0] Dis_pc;
    logic        Dis_pred;
    logic [3:0]  ROB_free_idx;
    logic        ROB_full;
    logic [3:0]  Q1_idx, Q2_idx;
    logic        Q1_ready, Q2_ready;
    logic [31:0] Q1_val, Q2_val;
    logic        CDB_flag;
    logic [3:0]  CDB_idx;
    logic [31:0] CDB_val;
    logic        CDB_taken;
    logic [31:0] CDB_target;
    logic        ROB_flag;
    logic [3:0]  ROB_new_idx;
    logic [4:0]  ROB_rd;
    logic [31:0] ROB_val;
    logic        Store_commit, roll;
    logic [31:0] roll_pc;

    int nchk = 0;
    int nerr = 0;

    rob_commit #(.ROB_SIZE(16), .ROB_IDX_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .Dis_flag(Dis_flag), .Dis_type(Dis_type), .Dis_rd(Dis_rd), .Dis_pc(Dis_pc), .Dis_pred(Dis_pred),
        .ROB_free_idx(ROB_free_idx), .ROB_full(ROB_full),
        .Q1_idx(Q1_idx), .Q1_ready(Q1_ready), .Q1_val(Q1_val),
        .Q2_idx(Q2_idx), .Q2_ready(Q2_ready), .Q2_val(Q2_val),
        .CDB_flag(CDB_flag), .CDB_idx(CDB_idx), .CDB_val(CDB_val),
        .CDB_taken(CDB_taken), .CDB_target(CDB_target),
        .ROB_flag(ROB_flag), .ROB_new_idx(ROB_new_idx), .ROB_rd(ROB_rd), .ROB_val(ROB_val),
        .Store_commit(Store_commit), .roll(roll), .roll_pc(roll_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model: ordered queue of in-flight instructions ----------------
    typedef struct {
        logic [3:0]  tag;
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic [31:0] pc;
        bit          pred;
        bit          done;
        logic [31:0] val;
        bit          taken;
        logic [31:0] target;
    } mentry_t;

    mentry_t     m_q[$];
    int          m_head;
    bit          e_flag, e_store, e_roll;
    logic [3:0]  e_idx;
    logic [4:0]  e_rd;
    logic [31:0] e_val, e_rpc;

    task automatic m_reset();
        m_q.delete();
        m_head  = 0;
        e_flag  = 0; e_store = 0; e_roll = 0;
        e_idx   = '0; e_rd = '0; e_val = '0; e_rpc = '0;
    endtask

    task automatic m_query(input logic [3:0] q, output bit r, output logic [31:0] v);
        r = 0; v = '0;
        if (CDB_flag && CDB_idx == q) begin
            r = 1; v = CDB_val;
        end else begin
            foreach (m_q[i]) if (m_q[i].tag == q && m_q[i].done) begin r = 1; v = m_q[i].val; end
        end
    endtask

    task automatic m_edge();
        mentry_t e, d;
        bit      full_pre;
        int      tail_pre;
        if (e_roll) begin
            m_q.delete();
            m_head = 0;
            e_flag = 0; e_store = 0; e_roll = 0;
        end else if (rdy) begin
            full_pre = (m_q.size() == 16);
            tail_pre = (m_head + m_q.size()) % 16;
            if (CDB_flag) begin
                foreach (m_q[i]) if (m_q[i].tag == CDB_idx) begin
                    m_q[i].done = 1; m_q[i].val = CDB_val;
                    m_q[i].taken = CDB_taken; m_q[i].target = CDB_target;
                end
            end
            if (m_q.size() > 0 && m_q[0].done) begin
                e = m_q.pop_front();
                e_flag  = 1;
                e_idx   = e.tag;
                e_val   = e.val;
                e_rd    = (e.typ == 2'd0) ? e.rd : 5'd0;
                e_store = (e.typ == 2'd2);
                if (e.typ == 2'd1 && e.taken != e.pred) begin
                    e_roll = 1;
                    e_rpc  = e.taken ? e.target : e.pc + 32'd4;
                end
                m_head = (m_head + 1) % 16;
            end else begin
                e_flag = 0; e_store = 0;
            end
            if (Dis_flag && !full_pre) begin
                d = '{tag: 4'(tail_pre), typ: Dis_type, rd: Dis_rd, pc: Dis_pc, pred: Dis_pred,
                      done: 0, val: '0, taken: 0, target: '0};
                m_q.push_back(d);
            end
        end
    endtask

    // One clock: check combinational outputs, take the edge, check registered outputs.
    task automatic cyc();
        bit r; logic [31:0] v; int n;
        #1;
        n = m_q.size();
        chk("free_idx", 32'(ROB_free_idx), 32'((m_head + n) % 16));
        chk("full", 32'(ROB_full), 32'(n == 16));
        m_query(Q1_idx, r, v);
        chk("q1_ready", 32'(Q1_ready), 32'(r));
        chk("q1_val", Q1_val, v);
        m_query(Q2_idx, r, v);
        chk("q2_ready", 32'(Q2_ready), 32'(r));
        chk("q2_val", Q2_val, v);
        @(posedge clk); #1;
        m_edge();
        chk("rob_flag", 32'(ROB_flag), 32'(e_flag));
        chk("store_commit", 32'(Store_commit), 32'(e_store));
        chk("roll", 32'(roll), 32'(e_roll));
        chk("roll_pc", roll_pc, e_rpc);
        if (e_flag) begin
            chk("new_idx", 32'(ROB_new_idx), 32'(e_idx));
            chk("rob_rd", 32'(ROB_rd), 32'(e_rd));
            chk("rob_val", ROB_val, e_val);
        end
    endtask

    task automatic idle_inputs();
        rdy = 1'b1; Dis_flag = 1'b0; Dis_type = 2'd0; Dis_rd = '0; Dis_pc = '0; Dis_pred = 1'b0;
        CDB_flag = 1'b0; CDB_idx = '0; CDB_val = '0; CDB_taken = 1'b0; CDB_target = '0;
        Q1_idx = '0; Q2_idx = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_reset();
    endtask

    task automatic dispatch(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc, input bit pred);
        Dis_flag = 1'b1; Dis_type = t; Dis_rd = rd; Dis_pc = pc; Dis_pred = pred;
        cyc();
        Dis_flag = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] idx, input logic [31:0] val, input bit tk, input logic [31:0] tgt);
        CDB_flag = 1'b1; CDB_idx = idx; CDB_val = val; CDB_taken = tk; CDB_target = tgt;
        cyc();
        CDB_flag = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit rdy, dis; logic [1:0] dtyp; logic [4:0] drd; logic [31:0] dpc; bit dpred;
        bit cf; logic [3:0] cidx; logic [31:0] cval; bit ctk; logic [31:0] ctgt;
        logic [3:0] q1;
        logic [3:0] x_free; bit x_full, x_qr; logic [31:0] x_qv;
        bit x_flag; logic [3:0] x_idx; logic [4:0] x_rd; logic [31:0] x_val; bit x_st, x_roll; logic [31:0] x_rpc;
    } vec_t;

    vec_t vt[9];

    initial begin
        // reg write rd5 -> CDB DEAD -> commit next edge
        vt[0] = '{1'b1,1'b1,2'd0,5'd5,32'h100,1'b0, 1'b0,4'd0,32'h0,1'b0,32'h0, 4'd0,
                  4'd0,1'b0,1'b0,32'h0, 1'b0,4'd0,5'd0,32'h0,1'b0,1'b0,32'h0};
        vt[1] = '{1'b1,1'b0,2'd0,5'd0,32'h0,1'b0, 1'b1,4'd0,32'hDEAD,1'b0,32'h0, 4'd0,
                  4'd1,1'b0,1'b1,32'hDEAD, 1'b1,4'd0,5'd5,32'hDEAD,1'b0,1'b0,32'h0};
        vt[2] = '{1'b1,1'b0,2'd0,5'd0,32'h0,1'b0, 1'b0,4'd0,32'h0,1'b0,32'h0, 4'd0,
                  4'd1,1'b0,1'b0,32'h0, 1'b0,4'd0,5'd5,32'hDEAD,1'b0,1'b0,32'h0};
        // store tag1, then branch tag2 (pred taken) while store completes
        vt[3] = '{1'b1,1'b1,2'd2,5'd7,32'h104,1'b0, 1'b0,4'd0,32'h0,1'b0,32'h0, 4'd0,
                  4'd1,1'b0,1'b0,32'h0, 1'b0,4'd0,5'd5,32'hDEAD,1'b0,1'b0,32'h0};
        vt[4] = '{1'b1,1'b1,2'd1,5'd0,32'h200,1'b1, 1'b1,4'd1,32'h55,1'b0,32'h0, 4'd1,
                  4'd2,1'b0,1'b1,32'h55, 1'b1,4'd1,5'd0,32'h55,1'b1,1'b0,32'h0};
        // branch resolves not taken -> roll to pc+4
        vt[5] = '{1'b1,1'b0,2'd0,5'd0,32'h0,1'b0, 1'b1,4'd2,32'h0,1'b0,32'h999, 4'd1,
                  4'd3,1'b0,1'b0,32'h0, 1'b1,4'd2,5'd0,32'h0,1'b0,1'b1,32'h204};
        // roll cycle: dispatch ignored
        vt[6] = '{1'b1,1'b1,2'd0,5'd3,32'h300,1'b0, 1'b0,4'd0,32'h0,1'b0,32'h0, 4'd0,
                  4'd3,1'b0,1'b0,32'h0, 1'b0,4'd2,5'd0,32'h0,1'b0,1'b0,32'h204};
        // rdy=0: query bypass still live, dispatch/CDB dropped
        vt[7] = '{1'b0,1'b1,2'd0,5'd3,32'h300,1'b0, 1'b1,4'd0,32'h7,1'b0,32'h0, 4'd0,
                  4'd0,1'b0,1'b1,32'h7, 1'b0,4'd2,5'd0,32'h0,1'b0,1'b0,32'h204};
        vt[8] = '{1'b1,1'b0,2'd0,5'd0,32'h0,1'b0, 1'b0,4'd0,32'h0,1'b0,32'h0, 4'd0,
                  4'd0,1'b0,1'b0,32'h0, 1'b0,4'd2,5'd0,32'h0,1'b0,1'b0,32'h204};
    end

    initial begin
        do_reset();
        chk("rst_flag", 32'(ROB_flag), 32'd0);
        chk("rst_store", 32'(Store_commit), 32'd0);
        chk("rst_roll", 32'(roll), 32'd0);
        chk("rst_new_idx", 32'(ROB_new_idx), 32'd0);
        chk("rst_rd", 32'(ROB_rd), 32'd0);
        chk("rst_val", ROB_val, 32'd0);
        chk("rst_roll_pc", roll_pc, 32'd0);
        chk("rst_free", 32'(ROB_free_idx), 32'd0);
        chk("rst_full", 32'(ROB_full), 32'd0);

        for (int i = 0; i < 9; i++) begin
            rdy = vt[i].rdy; Dis_flag = vt[i].dis; Dis_type = vt[i].dtyp; Dis_rd = vt[i].drd;
            Dis_pc = vt[i].dpc; Dis_pred = vt[i].dpred;
            CDB_flag = vt[i].cf; CDB_idx = vt[i].cidx; CDB_val = vt[i].cval;
            CDB_taken = vt[i].ctk; CDB_target = vt[i].ctgt;
            Q1_idx = vt[i].q1; Q2_idx = vt[i].q1;
            #1;
            chk($sformatf("v%0d_free", i), 32'(ROB_free_idx), 32'(vt[i].x_free));
            chk($sformatf("v%0d_full", i), 32'(ROB_full), 32'(vt[i].x_full));
            chk($sformatf("v%0d_q1r", i), 32'(Q1_ready), 32'(vt[i].x_qr));
            chk($sformatf("v%0d_q1v", i), Q1_val, vt[i].x_qv);
            chk($sformatf("v%0d_q2r", i), 32'(Q2_ready), 32'(vt[i].x_qr));
            @(posedge clk); #1;
            chk($sformatf("v%0d_flag", i), 32'(ROB_flag), 32'(vt[i].x_flag));
            chk($sformatf("v%0d_idx", i), 32'(ROB_new_idx), 32'(vt[i].x_idx));
            chk($sformatf("v%0d_rd", i), 32'(ROB_rd), 32'(vt[i].x_rd));
            chk($sformatf("v%0d_val", i), ROB_val, vt[i].x_val);
            chk($sformatf("v%0d_store", i), 32'(Store_commit), 32'(vt[i].x_st));
            chk($sformatf("v%0d_roll", i), 32'(roll), 32'(vt[i].x_roll));
            chk($sformatf("v%0d_roll_pc", i), roll_pc, vt[i].x_rpc);
        end

        // Fill to 16, drop the 17th, commit one, next allocation wraps to tag 0.
        do_reset();
        for (int i = 0; i < 16; i++) dispatch(2'd0, 5'(i + 1), 32'(32'h1000 + 4 * i), 1'b0);
        chk("fill_full", 32'(ROB_full), 32'd1);
        chk("fill_free", 32'(ROB_free_idx), 32'd0);
        dispatch(2'd0, 5'd20, 32'h2000, 1'b0);
        chk("drop_free", 32'(ROB_free_idx), 32'd0);
        cdb(4'd0, 32'h11, 1'b0, 32'h0);
        chk("fill_commit_flag", 32'(ROB_flag), 32'd1);
        chk("fill_commit_idx", 32'(ROB_new_idx), 32'd0);
        chk("after_commit_full", 32'(ROB_full), 32'd0);
        chk("wrap_free", 32'(ROB_free_idx), 32'd0);
        dispatch(2'd0, 5'd9, 32'h3000, 1'b0);
        chk("wrap_free_next", 32'(ROB_free_idx), 32'd1);

        // Out-of-order completion, in-order retirement on consecutive cycles.
        do_reset();
        for (int i = 0; i < 3; i++) dispatch(2'd0, 5'(i + 1), 32'(32'h500 + 4 * i), 1'b0);
        cdb(4'd2, 32'h22, 1'b0, 32'h0);
        chk("ooo_flag2", 32'(ROB_flag), 32'd0);
        cdb(4'd1, 32'h21, 1'b0, 32'h0);
        chk("ooo_flag1", 32'(ROB_flag), 32'd0);
        cdb(4'd0, 32'h20, 1'b0, 32'h0);
        chk("ooo_c0", 32'(ROB_new_idx), 32'(ROB_flag ? 0 : 99));
        cyc();
        chk("ooo_c1", 32'(ROB_new_idx), 32'(ROB_flag ? 1 : 99));
        cyc();
        chk("ooo_c2", 32'(ROB_new_idx), 32'(ROB_flag ? 2 : 99));
        cyc();
        chk("ooo_idle", 32'(ROB_flag), 32'd0);

        // Mispredict (pred not-taken, actually taken): younger ready entries never commit.
        do_reset();
        dispatch(2'd1, 5'd0, 32'h300, 1'b0);
        dispatch(2'd0, 5'd4, 32'h304, 1'b0);
        dispatch(2'd0, 5'd6, 32'h308, 1'b0);
        cdb(4'd1, 32'h1, 1'b0, 32'h0);
        cdb(4'd2, 32'h2, 1'b0, 32'h0);
        cdb(4'd0, 32'h0, 1'b1, 32'h400);
        chk("mp_roll", 32'(roll), 32'd1);
        chk("mp_roll_pc", roll_pc, 32'h400);
        chk("mp_idx", 32'(ROB_new_idx), 32'd0);
        cyc();
        chk("mp_roll_clear", 32'(roll), 32'd0);
        chk("mp_no_young", 32'(ROB_flag), 32'd0);
        chk("mp_tail", 32'(ROB_free_idx), 32'd0);
        cyc();
        chk("mp_no_young2", 32'(ROB_flag), 32'd0);

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int sel;
            rdy      = ($urandom_range(0, 7) != 0);
            Dis_flag = $urandom_range(0, 1) == 1;
            sel      = $urandom_range(0, 7);
            Dis_type = (sel == 4) ? 2'd2 : (sel == 5) ? 2'd3 : (sel == 6) ? 2'd1 : 2'd0;
            Dis_rd   = 5'($urandom);
            Dis_pc   = $urandom;
            Dis_pred = $urandom_range(0, 1) == 1;
            CDB_flag = $urandom_range(0, 2) != 0;
            if (m_q.size() > 0 && $urandom_range(0, 3) != 0)
                CDB_idx = m_q[$urandom_range(0, m_q.size() - 1)].tag;
            else
                CDB_idx = 4'($urandom);
            CDB_val    = $urandom;
            CDB_taken  = $urandom_range(0, 3) == 0;
            CDB_target = $urandom;
            Q1_idx     = 4'($urandom);
            Q2_idx     = ($urandom_range(0, 1) == 1) ? CDB_idx : 4'($urandom);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
